// File: rtl/clk_div_pkg.sv
// Shared definitions for the run-time clock-divider controller:
// controller state encoding and the default widths / half-period.
package clk_div_pkg;

    // Default counter and half-period width.
    localparam int CW_DEFAULT = 8;

    // Half-period loaded at reset; 25 gives divide-by-50.
    localparam int DEFAULT_HALF_DEFAULT = 25;

    // Controller state: idle with clk_out parked low, or generating clk_out.
    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/half_period_counter.sv
// Half-period counter: counts clk cycles up to the programmed half-period,
// then toggles clk_out. Held at zero with clk_out low while cleared.
module half_period_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          run,
    input  logic [CW-1:0] half,
    output logic          clk_out,
    output logic          wrap,
    output logic          fall
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt;

    // Last cycle of a half-period; fall marks the wrap that ends a period.
    assign wrap = run && (cnt == half - ONE);
    assign fall = wrap && clk_out;

    // Count through the half-period and toggle clk_out on every wrap.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else if (run) begin
            cnt     <= cnt + ONE;
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run-time clock-divider controller. Produces clk_out with a programmable
// half-period; start, stop and retunes only take effect at a period boundary
// (the falling wrap), so every phase lasts its full programmed length.
module clkdiv_ctrl
    import clk_div_pkg::*;
#(
    parameter int CW           = CW_DEFAULT,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_half,
    output logic          cfg_ready,
    output logic          clk_out,
    output logic          rise_tick,
    output logic          busy,
    output logic          err
);

    state_t        state;
    logic [CW-1:0] active_half;
    logic [CW-1:0] shadow_half;
    logic          pending;

    logic          running;
    logic          wrap;
    logic          fall;
    logic          boundary;
    logic          accept;
    logic          cfg_zero;

    assign running   = (state == RUN);
    assign boundary  = running && fall;
    assign cfg_ready = !pending;
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_zero  = (cfg_half == '0);
    assign busy      = running;

    half_period_counter #(
        .CW (CW)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (!running),
        .run     (running),
        .half    (active_half),
        .clk_out (clk_out),
        .wrap    (wrap),
        .fall    (fall)
    );

    // Run/stop sequencing: start on en, stop only at a period boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STOP;
        end else if (!running) begin
            if (en) state <= RUN;
        end else if (boundary && !en) begin
            state <= STOP;
        end
    end

    // Config shadow: hold an accepted half-period until it can be applied.
    // Accept and apply are exclusive since accept requires pending low, and
    // the boundary sees pre-edge pending, so a boundary-edge accept waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_half <= CW'(DEFAULT_HALF);
            shadow_half <= CW'(DEFAULT_HALF);
            pending     <= 1'b0;
        end else if (pending && (!running || boundary)) begin
            active_half <= shadow_half;
            pending     <= 1'b0;
        end else if (accept && !cfg_zero) begin
            shadow_half <= cfg_half;
            pending     <= 1'b1;
        end
    end

    // Registered one-cycle pulses: rise alongside the 0->1 toggle, err on a
    // zero half-period accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_tick <= 1'b0;
            err       <= 1'b0;
        end else begin
            rise_tick <= wrap && !clk_out;
            err       <= accept && cfg_zero;
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Testbench for clkdiv_ctrl: expected rise cycles are pushed to a scoreboard
// queue when stimulus is driven and popped by a monitor on every rise_tick.
module tb_clkdiv_ctrl;

    localparam int CW = 8;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          en        = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [CW-1:0] cfg_half  = '0;
    logic          cfg_ready;
    logic          clk_out;
    logic          rise_tick;
    logic          busy;
    logic          err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int exp_q[$];

    clkdiv_ctrl #(
        .CW           (CW),
        .DEFAULT_HALF (25)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Edge counter: at a falling edge, cyc is the number of the last rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every rise_tick must match the next expected cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (rise_tick) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rise_time: rise_tick at cycle %0d, expected none", cyc);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (e != cyc) begin
                        fails++;
                        $display("FAIL rise_time: rise_tick at cycle %0d, expected %0d", cyc, e);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
                tests++;
                fails++;
                $display("FAIL rise_missed: no rise_tick at cycle %0d (now %0d)", exp_q[0], cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start_run(output int k);
        en = 1'b1;
        k  = cyc + 1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d rises outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (clk_out !== 1'b0)   begin fails++; $display("FAIL reset_clk_out: got %b, expected 0", clk_out); end
        tests++; if (rise_tick !== 1'b0) begin fails++; $display("FAIL reset_rise_tick: got %b, expected 0", rise_tick); end
        tests++; if (err !== 1'b0)       begin fails++; $display("FAIL reset_err: got %b, expected 0", err); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready: got %b, expected 1", cfg_ready); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL idle_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_default_start();
        int k;
        int hi = 0;
        int lo = 0;
        do_reset();
        start_run(k);
        exp_q.push_back(k + 25);
        exp_q.push_back(k + 75);
        exp_q.push_back(k + 125);
        wait_cyc(k + 1);
        tests++; if (busy !== 1'b1)    begin fails++; $display("FAIL start_busy: got %b, expected 1", busy); end
        tests++; if (clk_out !== 1'b0) begin fails++; $display("FAIL start_low: got %b, expected 0", clk_out); end
        wait_cyc(k + 25);
        while (clk_out === 1'b1 && hi < 100) begin @(negedge clk); hi++; end
        while (clk_out === 1'b0 && lo < 100) begin @(negedge clk); lo++; end
        tests++; if (hi != 25) begin fails++; $display("FAIL default_high_len: got %0d, expected 25", hi); end
        tests++; if (lo != 25) begin fails++; $display("FAIL default_low_len: got %0d, expected 25", lo); end
        wait_drain("default", 200);
    endtask

    task automatic test_retune();
        int k;
        do_reset();
        start_run(k);
        exp_q.push_back(k + 25);
        exp_q.push_back(k + 54);
        exp_q.push_back(k + 62);
        exp_q.push_back(k + 70);
        wait_cyc(k + 9);
        cfg_valid = 1'b1;
        cfg_half  = 8'd4;
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL retune_ready_pre: got %b, expected 1", cfg_ready); end
        @(negedge clk);
        cfg_valid = 1'b0;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL retune_ready_accept: got %b, expected 0", cfg_ready); end
        wait_cyc(k + 49);
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL retune_ready_hold: got %b, expected 0", cfg_ready); end
        wait_cyc(k + 50);
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL retune_ready_boundary: got %b, expected 1", cfg_ready); end
        tests++; if (clk_out !== 1'b0)   begin fails++; $display("FAIL retune_boundary_low: got %b, expected 0", clk_out); end
        wait_drain("retune", 100);
    endtask

    task automatic test_stop();
        int k;
        do_reset();
        start_run(k);
        exp_q.push_back(k + 25);
        exp_q.push_back(k + 75);
        wait_cyc(k + 85);
        en = 1'b0;
        wait_cyc(k + 99);
        tests++; if (clk_out !== 1'b1) begin fails++; $display("FAIL stop_high_kept: got %b, expected 1", clk_out); end
        tests++; if (busy !== 1'b1)    begin fails++; $display("FAIL stop_busy_kept: got %b, expected 1", busy); end
        wait_cyc(k + 100);
        tests++; if (clk_out !== 1'b0) begin fails++; $display("FAIL stop_clk_out: got %b, expected 0", clk_out); end
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL stop_busy: got %b, expected 0", busy); end
        tests++; if (dut.u_counter.cnt !== 8'd0) begin fails++; $display("FAIL stop_cnt: got %0d, expected 0", dut.u_counter.cnt); end
        wait_cyc(k + 160);
        tests++; if (clk_out !== 1'b0) begin fails++; $display("FAIL stop_parked: got %b, expected 0", clk_out); end
        wait_drain("stop", 10);
    endtask

    task automatic test_illegal();
        int k;
        do_reset();
        start_run(k);
        exp_q.push_back(k + 25);
        exp_q.push_back(k + 75);
        exp_q.push_back(k + 125);
        wait_cyc(k + 9);
        cfg_valid = 1'b1;
        cfg_half  = 8'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        tests++; if (err !== 1'b1)       begin fails++; $display("FAIL illegal_err: got %b, expected 1", err); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL illegal_ready: got %b, expected 1", cfg_ready); end
        @(negedge clk);
        tests++; if (err !== 1'b0)       begin fails++; $display("FAIL illegal_err_pulse: got %b, expected 0", err); end
        wait_drain("illegal", 200);
    endtask

    task automatic test_boundary_accept();
        int k;
        do_reset();
        start_run(k);
        exp_q.push_back(k + 25);
        exp_q.push_back(k + 75);
        exp_q.push_back(k + 103);
        exp_q.push_back(k + 109);
        wait_cyc(k + 49);
        cfg_valid = 1'b1;
        cfg_half  = 8'd3;
        wait_cyc(k + 50);
        cfg_valid = 1'b0;
        tests++; if (clk_out !== 1'b0)   begin fails++; $display("FAIL bnd_fall: got %b, expected 0", clk_out); end
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL bnd_ready_accept: got %b, expected 0", cfg_ready); end
        wait_cyc(k + 99);
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL bnd_ready_hold: got %b, expected 0", cfg_ready); end
        wait_cyc(k + 100);
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL bnd_ready_apply: got %b, expected 1", cfg_ready); end
        wait_drain("bnd", 150);
    endtask

    task automatic test_div2();
        int k;
        do_reset();
        cfg_valid = 1'b1;
        cfg_half  = 8'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL div2_ready_accept: got %b, expected 0", cfg_ready); end
        @(negedge clk);
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL div2_ready_stop_apply: got %b, expected 1", cfg_ready); end
        start_run(k);
        exp_q.push_back(k + 1);
        exp_q.push_back(k + 3);
        exp_q.push_back(k + 5);
        wait_cyc(k + 1);
        for (int i = 0; i < 4; i++) begin
            logic want;
            want = (i % 2 == 0);
            tests++;
            if (clk_out !== want) begin
                fails++;
                $display("FAIL div2_wave: cycle %0d got %b, expected %b", cyc, clk_out, want);
            end
            @(negedge clk);
        end
        en = 1'b0;
        wait_cyc(k + 7);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL div2_stop_busy: got %b, expected 0", busy); end
        wait_drain("div2", 10);
    endtask

    task automatic test_reset_pending();
        int k;
        int k2;
        do_reset();
        start_run(k);
        exp_q.push_back(k + 25);
        wait_cyc(k + 9);
        cfg_valid = 1'b1;
        cfg_half  = 8'd7;
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_cyc(k + 30);
        tests++; if (clk_out !== 1'b1)   begin fails++; $display("FAIL rstp_pre_high: got %b, expected 1", clk_out); end
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL rstp_pre_pending: got %b, expected 0", cfg_ready); end
        #2 rst = 1'b0;
        #1;
        tests++; if (clk_out !== 1'b0)   begin fails++; $display("FAIL rstp_clk_out: got %b, expected 0", clk_out); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rstp_busy: got %b, expected 0", busy); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rstp_cfg_ready: got %b, expected 1", cfg_ready); end
        en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        start_run(k2);
        exp_q.push_back(k2 + 25);
        exp_q.push_back(k2 + 75);
        exp_q.push_back(k2 + 125);
        wait_drain("rstp", 200);
    endtask

    initial begin
        test_reset();
        test_default_start();
        test_retune();
        test_stop();
        test_illegal();
        test_boundary_accept();
        test_div2();
        test_reset_pending();
        do_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
